// File: rtl/permute_sched_pkg.sv
// permute_sched_pkg: shared lane element, mode and state types for the permutation engine
package permute_sched_pkg;
    localparam int N_LANES = 4;
    typedef struct packed {
        logic       f0;
        logic [1:0] f1;
    } elem_t;
    typedef enum logic [1:0] {
        MODE_ID   = 2'd0,
        MODE_HALF = 2'd1,
        MODE_PAIR = 2'd2,
        MODE_REV  = 2'd3
    } mode_e;
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;
    // Every mode is an XOR on the lane index: half flips bit 1, pair flips bit 0, reverse flips both.
    function automatic logic [1:0] src_lane(input logic [1:0] k, input logic [1:0] m);
        return k ^ {m[0], m[1]};
    endfunction
endpackage

// File: rtl/permute_sched_lanes.sv
// permute_lanes: combinational 4-lane permutation
// Ports: lanes_i (4 elements in), mode_i (permutation mode), lanes_o (permuted elements).
module permute_lanes
    import permute_sched_pkg::*;
(
    input  elem_t [N_LANES-1:0] lanes_i,
    input  mode_e               mode_i,
    output elem_t [N_LANES-1:0] lanes_o
);
    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        assign lanes_o[k] = lanes_i[src_lane(2'(k), mode_i)];
    end
endmodule

// File: rtl/permute_sched.sv
// permute_sched: scheduled 4-lane permutation with a registered valid/ready output stage
// Ports: CLK/ASYNCRESETN clock and async active-low reset; I_* input beat with valid/ready;
// cfg_we/cfg_sched/cfg_len schedule write, cfg_err rejected-write pulse;
// O_* permuted output beat with valid/ready, O_mode applied mode, O_last end of schedule frame.
module permute_sched
    import permute_sched_pkg::*;
#(
    parameter int SCHED_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       ASYNCRESETN,
    input  logic       I_valid,
    output logic       I_ready,
    input  logic       I_0__0,
    input  logic [1:0] I_0__1,
    input  logic       I_1__0,
    input  logic [1:0] I_1__1,
    input  logic       I_2__0,
    input  logic [1:0] I_2__1,
    input  logic       I_3__0,
    input  logic [1:0] I_3__1,
    input  logic       cfg_we,
    input  logic [7:0] cfg_sched,
    input  logic [1:0] cfg_len,
    output logic       cfg_err,
    output logic       O_valid,
    input  logic       O_ready,
    output logic       O_0__0,
    output logic [1:0] O_0__1,
    output logic       O_1__0,
    output logic [1:0] O_1__1,
    output logic       O_2__0,
    output logic [1:0] O_2__1,
    output logic       O_3__0,
    output logic [1:0] O_3__1,
    output logic [1:0] O_mode,
    output logic       O_last
);
    localparam int PW = $clog2(SCHED_DEPTH);
    state_e                     state_q;
    logic [PW-1:0]              ptr_q, ptr_d, len_q;
    logic [2*SCHED_DEPTH-1:0]   sched_q;
    elem_t [N_LANES-1:0]        out_q, in_lanes, perm_lanes;
    mode_e                      mode_q, cur_mode;
    logic                       last_q, err_q, can_take, accept, cfg_ok;
    assign in_lanes[0] = {I_0__0, I_0__1};
    assign in_lanes[1] = {I_1__0, I_1__1};
    assign in_lanes[2] = {I_2__0, I_2__1};
    assign in_lanes[3] = {I_3__0, I_3__1};
    // The output slot frees this cycle if empty or being consumed; a config write steals the slot.
    assign can_take = state_q == ST_EMPTY || O_ready;
    assign I_ready  = can_take && !cfg_we;
    assign accept   = I_valid && I_ready;
    assign cfg_ok   = cfg_we && can_take;
    assign cur_mode = mode_e'(sched_q[{ptr_q, 1'b0} +: 2]);
    assign ptr_d    = cfg_ok ? '0 : !accept ? ptr_q : (ptr_q == len_q) ? '0 : ptr_q + 1'b1;
    permute_lanes u_perm (
        .lanes_i (in_lanes),
        .mode_i  (cur_mode),
        .lanes_o (perm_lanes)
    );
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            len_q   <= '0;
            sched_q <= '0;
            out_q   <= '0;
            mode_q  <= MODE_ID;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= cfg_we && !can_take;
            if (cfg_ok) begin
                sched_q <= cfg_sched;
                len_q   <= cfg_len;
            end
            if (accept) begin
                state_q <= ST_FULL;
                out_q   <= perm_lanes;
                mode_q  <= cur_mode;
                last_q  <= ptr_q == len_q;
            end else if (O_ready) begin
                state_q <= ST_EMPTY;
            end
        end
    end
    assign O_valid = state_q == ST_FULL;
    assign cfg_err = err_q;
    assign O_mode  = mode_q;
    assign O_last  = last_q;
    assign {O_0__0, O_0__1} = out_q[0];
    assign {O_1__0, O_1__1} = out_q[1];
    assign {O_2__0, O_2__1} = out_q[2];
    assign {O_3__0, O_3__1} = out_q[3];
endmodule

// File: tb/tb_permute_sched.sv
// tb_permute_sched: scoreboard bench for permute_sched with a table-driven reference model
module tb_permute_sched;
    logic       CLK = 1'b0, ASYNCRESETN = 1'b0;
    logic       I_valid = 1'b0, I_ready;
    logic       I_0__0 = 1'b0, I_1__0 = 1'b0, I_2__0 = 1'b0, I_3__0 = 1'b0;
    logic [1:0] I_0__1 = '0, I_1__1 = '0, I_2__1 = '0, I_3__1 = '0;
    logic       cfg_we = 1'b0, cfg_err;
    logic [7:0] cfg_sched = '0;
    logic [1:0] cfg_len = '0;
    logic       O_valid, O_ready = 1'b0;
    logic       O_0__0, O_1__0, O_2__0, O_3__0;
    logic [1:0] O_0__1, O_1__1, O_2__1, O_3__1, O_mode;
    logic       O_last;

    permute_sched #(.SCHED_DEPTH(4)) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .I_valid(I_valid), .I_ready(I_ready),
        .I_0__0(I_0__0), .I_0__1(I_0__1), .I_1__0(I_1__0), .I_1__1(I_1__1),
        .I_2__0(I_2__0), .I_2__1(I_2__1), .I_3__0(I_3__0), .I_3__1(I_3__1),
        .cfg_we(cfg_we), .cfg_sched(cfg_sched), .cfg_len(cfg_len), .cfg_err(cfg_err),
        .O_valid(O_valid), .O_ready(O_ready),
        .O_0__0(O_0__0), .O_0__1(O_0__1), .O_1__0(O_1__0), .O_1__1(O_1__1),
        .O_2__0(O_2__0), .O_2__1(O_2__1), .O_3__0(O_3__0), .O_3__1(O_3__1),
        .O_mode(O_mode), .O_last(O_last)
    );

    always #5 CLK = ~CLK;

    int checks = 0, failures = 0;
    logic [14:0] sb[$];
    logic [7:0]  m_sched = '0;
    logic [1:0]  m_len = '0, m_ptr = '0;
    logic        err_exp = 1'b0;
    // Output lane k takes input lane perm[mode][k].
    int perm [4][4] = '{'{0, 1, 2, 3}, '{2, 3, 0, 1}, '{1, 0, 3, 2}, '{3, 2, 1, 0}};
    localparam logic [11:0] BASE = {3'd1, 3'd2, 3'd3, 3'd4};

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] out_pack();
        return {O_0__0, O_0__1, O_1__0, O_1__1, O_2__0, O_2__1, O_3__0, O_3__1, O_mode, O_last};
    endfunction

    task automatic drive(input logic iv, input logic [11:0] lanes, input logic ordy,
                         input logic we, input logic [7:0] sch, input logic [1:0] ln);
        logic occ, exp_rdy;
        logic [1:0] md;
        logic [11:0] ex;
        @(negedge CLK);
        I_valid = iv;
        {I_0__0, I_0__1, I_1__0, I_1__1, I_2__0, I_2__1, I_3__0, I_3__1} = lanes;
        O_ready = ordy; cfg_we = we; cfg_sched = sch; cfg_len = ln;
        #1;
        occ = sb.size() != 0;
        exp_rdy = (!occ || ordy) && !we;
        chk("o_valid", 32'(O_valid), 32'(occ));
        chk("i_ready", 32'(I_ready), 32'(exp_rdy));
        chk("cfg_err", 32'(cfg_err), 32'(err_exp));
        err_exp = we && occ && !ordy;
        if (we && !err_exp) begin
            m_sched = sch; m_len = ln; m_ptr = '0;
        end
        if (iv && exp_rdy) begin
            md = 2'((m_sched >> (2 * m_ptr)) & 8'h3);
            for (int k = 0; k < 4; k++) ex[11-3*k -: 3] = lanes[11-3*perm[md][k] -: 3];
            sb.push_back({ex, md, m_ptr == m_len});
            m_ptr = (m_ptr == m_len) ? 2'd0 : m_ptr + 2'd1;
        end
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 12'h0, ordy, 1'b0, 8'h0, 2'd0);
    endtask

    task automatic mid_reset();
        @(negedge CLK);
        I_valid = 1'b0; cfg_we = 1'b0;
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        chk("rst_o_valid", 32'(O_valid), 32'd0);
        chk("rst_outputs", {17'd0, out_pack()}, 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        sb.delete();
        m_sched = '0; m_len = '0; m_ptr = '0; err_exp = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        ASYNCRESETN = 1'b1;
    endtask

    initial begin : monitor
        logic [14:0] e;
        forever begin
            @(negedge CLK);
            #3;
            if (ASYNCRESETN && O_valid && O_ready) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL beat_unexpected actual=%0h expected=none at %0t", out_pack(), $time);
                end else begin
                    e = sb.pop_front();
                    chk("beat", {17'd0, out_pack()}, {17'd0, e});
                end
            end
        end
    end

    initial begin : stim
        logic [14:0] snap;
        #12;
        chk("reset_o_valid", 32'(O_valid), 32'd0);
        chk("reset_outputs", {17'd0, out_pack()}, 32'd0);
        chk("reset_i_ready", 32'(I_ready), 32'd1);
        #2 ASYNCRESETN = 1'b1;
        // 1: identity pass-through after reset
        drive(1'b1, BASE, 1'b1, 1'b0, 8'h0, 2'd0);
        idle(1'b1);
        chk("t1_out", {17'd0, out_pack()}, {17'd0, BASE, 2'd0, 1'b1});
        // 2: full four-entry schedule, five back-to-back beats
        drive(1'b0, BASE, 1'b1, 1'b1, 8'b11_10_01_00, 2'd3);
        repeat (5) drive(1'b1, BASE, 1'b1, 1'b0, 8'h0, 2'd0);
        idle(1'b1);
        chk("t2_fifth", {17'd0, out_pack()}, {17'd0, BASE, 2'd0, 1'b0});
        idle(1'b1);
        // 3: stall with valid held, outputs stable, then release
        drive(1'b1, BASE, 1'b1, 1'b0, 8'h0, 2'd0);
        drive(1'b1, {3'd7, 3'd6, 3'd5, 3'd0}, 1'b0, 1'b0, 8'h0, 2'd0);
        snap = out_pack();
        repeat (3) begin
            drive(1'b1, {3'd7, 3'd6, 3'd5, 3'd0}, 1'b0, 1'b0, 8'h0, 2'd0);
            chk("stall_hold", {17'd0, out_pack()}, {17'd0, snap});
        end
        drive(1'b1, {3'd7, 3'd6, 3'd5, 3'd0}, 1'b1, 1'b0, 8'h0, 2'd0);
        idle(1'b1);
        // 4: rejected write while full and stalled, then accepted retry
        drive(1'b1, BASE, 1'b1, 1'b0, 8'h0, 2'd0);
        drive(1'b0, BASE, 1'b0, 1'b1, 8'b00_00_00_11, 2'd0);
        idle(1'b0);
        idle(1'b0);
        drive(1'b0, BASE, 1'b1, 1'b1, 8'b00_00_00_11, 2'd0);
        drive(1'b1, BASE, 1'b1, 1'b0, 8'h0, 2'd0);
        drive(1'b1, BASE, 1'b1, 1'b0, 8'h0, 2'd0);
        idle(1'b1);
        // 5: two-entry schedule alternating half and pair swap
        drive(1'b0, BASE, 1'b1, 1'b1, 8'b00_00_10_01, 2'd1);
        repeat (4) drive(1'b1, BASE, 1'b1, 1'b0, 8'h0, 2'd0);
        // 6: asynchronous reset with a beat held
        drive(1'b1, BASE, 1'b0, 1'b0, 8'h0, 2'd0);
        mid_reset();
        drive(1'b1, BASE, 1'b1, 1'b0, 8'h0, 2'd0);
        idle(1'b1);
        chk("t6_out", {17'd0, out_pack()}, {17'd0, BASE, 2'd0, 1'b1});
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) mid_reset();
            drive($urandom_range(0, 3) != 0, 12'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, 8'($urandom), 2'($urandom));
        end
        repeat (3) idle(1'b1);
        @(negedge CLK);
        #5;
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/permute_sched.md
# permute_sched

Sequenced 4-lane permutation engine for arrays of {bit, 2-bit} tuples. Each accepted input beat is permuted by the mode in the current entry of a programmable 4-entry schedule. The result is held in a registered output stage with valid/ready flow control. It sits upstream of consumers of the identity, half-swap and pair-swap lane orderings, and replaces the fixed fan-out of all orderings with one time-multiplexed datapath.

## Interface
Parameters:
- SCHED_DEPTH, 4, number of schedule entries. Fixed at 4; the pointer is 2 bits.

Ports:
- CLK  in  1  single clock, rising edge.
- ASYNCRESETN  in  1  reset, asynchronous, active-low.
- I_valid  in  1  input beat valid.
- I_ready  out  1  input beat accepted when I_valid && I_ready.
- I_k__0  in  1  lane k flag bit, k = 0..3.
- I_k__1  in  2  lane k payload, k = 0..3.
- cfg_we  in  1  schedule write strobe.
- cfg_sched  in  8  entry j mode = cfg_sched[2j+1:2j].
- cfg_len  in  2  active entries minus 1; 0 means 1 entry, 3 means 4 entries.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- O_valid  out  1  output beat valid.
- O_ready  in  1  output beat consumed when O_valid && O_ready.
- O_k__0  out  1  permuted lane k flag.
- O_k__1  out  2  permuted lane k payload.
- O_mode  out  2  mode applied to the held beat.
- O_last  out  1  held beat used entry cfg_len, which ends the schedule frame.

## Operation
Modes. Output lane k takes input lane p(k):
- 0, identity: p(k) = k.
- 1, half swap: p = (2,3,0,1).
- 2, pair swap: p = (1,0,3,2).
- 3, reverse: p = (3,2,1,0).

Output state machine:
- EMPTY: O_valid = 0. On accept, go to FULL and load the permuted lanes, O_mode, and O_last = (ptr == len).
- FULL: O_valid = 1.
  - O_ready with a simultaneous accept: stay in FULL and reload the output stage.
  - O_ready with no accept: go to EMPTY.
  - Otherwise hold all outputs stable.

Handshake rules:
- I_ready = (state == EMPTY || O_ready) && !cfg_we.
- I_ready has a combinational path from O_ready. This is deliberate and gives full throughput with one register stage.
- Input lanes are sampled only on accept. Lane values are never inspected; the flag bit is opaque data.

Schedule pointer ptr:
- On each accept, ptr advances to ptr + 1, wrapping to 0 after ptr == len.
- The pointer does not move on a cycle without an accept.

Configuration:
- cfg_we in EMPTY, or in FULL with O_ready set that cycle: load the schedule registers and len, and reset ptr to 0.
- cfg_we in FULL without O_ready: ignore the write, leave registers unchanged, and pulse cfg_err the next cycle.
- cfg_we always blocks input acceptance in its own cycle, so no beat straddles a schedule change.

## Timing
- Latency: an accept at edge n gives O_valid = 1 after edge n, i.e. 1 cycle.
- Throughput: 1 beat per cycle while O_ready stays high.
- Reset values:
  - state EMPTY, O_valid 0, all O lanes 0, O_mode 0, O_last 0, cfg_err 0.
  - ptr 0, len 0, all schedule entries mode 0.
  - After reset the block behaves as an identity pass-through.
- Reset asserted mid-operation drops any held beat immediately, with no completion.
- cfg_err is registered and is high for exactly one cycle per rejected write.

## Structure
- Shared package:
  - lane element struct {f0: 1 bit, f1: 2 bits}.
  - mode enum: MODE_ID = 0, MODE_HALF = 1, MODE_PAIR = 2, MODE_REV = 3.
  - constant N_LANES = 4.
- Sub-module permute_lanes: purely combinational, 4 elements plus 2-bit mode in, 4 elements out. It is instantiated once; the top holds the state machine, pointer, config registers and output stage.

## Test plan
Lanes are written as 3-bit {f0,f1}. Base input is (1,2,3,4), i.e. 3'b001, 3'b010, 3'b011, 3'b100.

1. Post-reset, O_ready = 1, base input → O = (1,2,3,4), O_mode = 0, O_last = 1, one cycle after accept.
2. cfg_sched = 8'b11_10_01_00, cfg_len = 3, four back-to-back beats → O = (1,2,3,4), (3,4,1,2), (2,1,4,3), (4,3,2,1). O_last is high only on the 4th beat; a 5th beat reuses mode 0.
3. O_ready = 0 for 3 cycles while I_valid is held → I_ready = 0, and O plus O_mode are stable across those cycles. Release O_ready → the next beat loads with no loss or duplication.
4. cfg_we while FULL with O_ready = 0 → cfg_err = 1 for one cycle and the schedule is unchanged. Retry with O_ready = 1 → accepted, ptr = 0.
5. cfg_len = 1 with cfg_sched = 8'bxx_xx_10_01 → modes alternate 1, 2, 1, 2. O_last is set on every 2nd beat.
6. Assert ASYNCRESETN low mid-stream between edges → O_valid drops immediately. After release, behaviour matches scenario 1.
